// File: rtl/auth_initiator.sv
// Authentication initiator: sends GET_DIGESTS then CHALLENGE over a level-held req/ack
// handshake, validates each response, retries on timeout and reports pass/fail.
module auth_initiator #(
    parameter int unsigned MSG_LEN        = 512,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned MAX_RETRIES    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         slot,
    input  logic [255:0]       nonce,
    output logic               req_out,
    output logic [MSG_LEN-1:0] auth_msg_req_out,
    input  logic               resp_req_in,
    input  logic [MSG_LEN-1:0] auth_msg_resp_in,
    output logic               Ack_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [7:0]         error_code,
    output logic [MSG_LEN-33:0] digests_out
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned RW = $clog2(MAX_RETRIES + 2);
    localparam int unsigned PW = MSG_LEN - 32;
    localparam int unsigned ZW = PW - 256;

    typedef enum logic [3:0] {
        StIdle, StSendDig, StWaitDig, StGapDig, StCheckDig,
        StSendChal, StWaitChal, StGapChal, StCheckChal, StReport
    } state_e;

    state_e             r_state, w_state;
    logic               r_req, w_req, r_ack, w_ack, r_busy, w_busy, r_done, w_done;
    logic               r_pass, w_pass;
    logic [7:0]         r_err, w_err, w_chk;
    logic [MSG_LEN-1:0] r_msg, w_msg, r_resp, w_resp, w_dig_msg, w_chal_msg;
    logic [PW-1:0]      r_dig, w_dig;
    logic [TW-1:0]      r_timer, w_timer;
    logic [RW-1:0]      r_retries, w_retries;
    logic [3:0]         r_slot, w_slot;
    logic [255:0]       r_nonce, w_nonce;
    logic               w_chal_phase;
    logic               w_unused_param2;

    // First failing check wins: version, then ERROR message, then unexpected type.
    function automatic logic [7:0] resp_err(input logic [23:0] hdr, input logic [7:0] exp_type);
        logic [7:0] ver, typ, p1;
        ver = hdr[23:16];
        typ = hdr[15:8];
        p1  = hdr[7:0];
        if (ver != 8'h01)          return 8'hFC;
        else if (typ == 8'h7F)     return (p1 == 8'h00) ? 8'hFF : p1;
        else if (typ != exp_type)  return 8'hFD;
        else                       return 8'h00;
    endfunction

    assign w_dig_msg  = {8'h01, 8'h81, 8'h00, 8'h00, {PW{1'b0}}};
    assign w_chal_msg = {8'h01, 8'h83, 4'h0, r_slot, 8'h00, r_nonce, {ZW{1'b0}}};
    assign w_chk      = resp_err(r_resp[MSG_LEN-1 -: 24],
                                 (r_state == StCheckChal) ? 8'h03 : 8'h01);
    assign w_chal_phase    = (r_state == StWaitChal);
    assign w_unused_param2 = ^r_resp[MSG_LEN-25 -: 8];

    always_comb begin
        w_state   = r_state;
        w_req     = r_req;
        w_ack     = 1'b0;
        w_done    = 1'b0;
        w_pass    = r_pass;
        w_err     = r_err;
        w_msg     = r_msg;
        w_resp    = r_resp;
        w_dig     = r_dig;
        w_timer   = r_timer;
        w_retries = r_retries;
        w_slot    = r_slot;
        w_nonce   = r_nonce;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_slot    = slot;
                    w_nonce   = nonce;
                    w_pass    = 1'b0;
                    w_err     = 8'h00;
                    w_retries = '0;
                    w_state   = StSendDig;
                end
            end
            StSendDig, StSendChal: begin
                w_msg   = (r_state == StSendDig) ? w_dig_msg : w_chal_msg;
                w_timer = '0;
                w_req   = 1'b1;
                w_state = (r_state == StSendDig) ? StWaitDig : StWaitChal;
            end
            StWaitDig, StWaitChal: begin
                // A response on the timeout edge takes priority over the retry.
                if (resp_req_in) begin
                    w_resp  = auth_msg_resp_in;
                    w_ack   = 1'b1;
                    w_req   = 1'b0;
                    w_state = w_chal_phase ? StCheckChal : StCheckDig;
                end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_req = 1'b0;
                    if (r_retries < RW'(MAX_RETRIES)) begin
                        w_retries = r_retries + 1'b1;
                        w_state   = w_chal_phase ? StGapChal : StGapDig;
                    end else begin
                        w_err   = 8'hFE;
                        w_pass  = 1'b0;
                        w_state = StReport;
                    end
                end else if (r_timer != '1) begin
                    w_timer = r_timer + 1'b1;
                end
            end
            StGapDig:  w_state = StSendDig;
            StGapChal: w_state = StSendChal;
            StCheckDig: begin
                if (w_chk != 8'h00) begin
                    w_err   = w_chk;
                    w_pass  = 1'b0;
                    w_state = StReport;
                end else begin
                    w_dig     = r_resp[PW-1:0];
                    w_retries = '0;
                    w_state   = StSendChal;
                end
            end
            StCheckChal: begin
                w_state = StReport;
                if (w_chk != 8'h00) begin
                    w_err  = w_chk;
                    w_pass = 1'b0;
                end else if (r_resp[MSG_LEN-21 -: 4] != r_slot) begin
                    w_err  = 8'hFB;
                    w_pass = 1'b0;
                end else begin
                    w_err  = 8'h00;
                    w_pass = 1'b1;
                end
            end
            StReport: begin
                w_done  = 1'b1;
                w_state = StIdle;
            end
            default: w_state = StIdle;
        endcase
        w_busy = (w_state != StIdle);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= StIdle;
            r_req     <= 1'b0;
            r_ack     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_err     <= 8'h00;
            r_msg     <= '0;
            r_resp    <= '0;
            r_dig     <= '0;
            r_timer   <= '0;
            r_retries <= '0;
            r_slot    <= '0;
            r_nonce   <= '0;
        end else begin
            r_state   <= w_state;
            r_req     <= w_req;
            r_ack     <= w_ack;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_pass    <= w_pass;
            r_err     <= w_err;
            r_msg     <= w_msg;
            r_resp    <= w_resp;
            r_dig     <= w_dig;
            r_timer   <= w_timer;
            r_retries <= w_retries;
            r_slot    <= w_slot;
            r_nonce   <= w_nonce;
        end
    end

    assign req_out          = r_req;
    assign auth_msg_req_out = r_msg;
    assign Ack_out          = r_ack;
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign error_code       = r_err;
    assign digests_out      = r_dig;

endmodule

// File: doc/auth_initiator.md
# auth_initiator

Authentication initiator that drives the responder's request side. It issues a GET_DIGESTS request, then a CHALLENGE request, over a level-held request/acknowledge handshake. It captures and checks each response, retries on timeout, and reports pass/fail with an error code to the policy layer. It sits directly upstream of the responder: its request outputs feed the responder's request inputs, and it consumes the responder's response outputs and returns Ack.

## Interface
- MSG_LEN, 512, message width in bits; header occupies the top 32 bits
- TIMEOUT_CYCLES, 1000, cycles waited for a response before a retry
- MAX_RETRIES, 2, resends allowed per request before failing
- clk  in  1  clock; all flops on posedge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins an authentication; ignored unless in IDLE
- slot  in  4  certificate slot placed in CHALLENGE Param1[3:0]
- nonce  in  256  challenge nonce; sampled on accepted start
- req_out  out  1  request valid; connects to responder resp_req_in
- auth_msg_req_out  out  MSG_LEN  request message; stable while req_out=1
- resp_req_in  in  1  response valid; from responder resp_req_out
- auth_msg_resp_in  in  MSG_LEN  response message
- Ack_out  out  1  one-cycle pulse; response consumed; connects to responder Ack_in
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of an authentication
- pass  out  1  valid with done; held until next accepted start
- error_code  out  8  0x00 on pass; held until next accepted start
- digests_out  out  MSG_LEN-32  payload of the accepted GET_DIGESTS response

## Operation
- Header fields, MSB first: ProtocolVersion[MSG_LEN-1:MSG_LEN-8], MessageType[-9:-16], Param1[-17:-24], Param2[-25:-32].
- Requests use ProtocolVersion=0x01 and Param2=0x00.
- GET_DIGESTS: MessageType=0x81, Param1=0x00, payload zero.
- CHALLENGE: MessageType=0x83, Param1={4'h0,slot}, payload={nonce, zeros}.
- Expected responses: DIGESTS MessageType=0x01; CHALLENGE_AUTH MessageType=0x03; ERROR MessageType=0x7F, with the responder error in Param1.
- States:
  - IDLE: on start, latch slot and nonce, clear pass/error_code/retry count, go to SEND_DIG.
  - SEND_DIG: drive the GET_DIGESTS request, clear timer, go to WAIT_DIG.
  - WAIT_DIG: hold req_out. On resp_req_in=1, capture the response, pulse Ack_out, drop req_out, go to CHECK_DIG. On timer==TIMEOUT_CYCLES-1, drop req_out. If retries<MAX_RETRIES, increment retries and go to GAP_DIG; otherwise fail with 0xFE.
  - GAP_DIG: one cycle with req_out=0, then SEND_DIG.
  - CHECK_DIG: the first failing check wins, in this order:
    - version≠0x01 → fail 0xFC
    - type 0x7F → fail with Param1 (if Param1=0x00, use 0xFF)
    - type≠0x01 → fail 0xFD
    - otherwise load digests_out, clear retries, go to SEND_CHAL.
  - SEND_CHAL / WAIT_CHAL / GAP_CHAL: identical to the digest states, using the CHALLENGE request.
  - CHECK_CHAL: same checks as CHECK_DIG with expected type 0x03. A valid CHALLENGE_AUTH with Param1[3:0]≠slot → fail 0xFB; otherwise pass.
  - REPORT: done=1 for one cycle, pass and error_code valid, then IDLE.
- Fail = load error_code, pass=0, go to REPORT.
- Timer: counts cycles in a WAIT state and saturates. Width is clog2(TIMEOUT_CYCLES)+1.
- A resp_req_in arriving while not in a WAIT state is not acknowledged.

## Timing
- Reset asserted (asynchronous) → state IDLE. req_out, Ack_out, busy, done, pass = 0; auth_msg_req_out, error_code, digests_out = 0; timer and retries = 0. All of this holds regardless of any transaction in flight.
- start sampled at posedge T → req_out=1 from T+2 (through SEND_DIG).
- Response sampled at posedge T in WAIT → Ack_out=1 and req_out=0 during T+1 → done at T+3 on a failing check.
- Response and timeout on the same edge: the response wins and no retry is issued.
- After a timeout, req_out stays low for at least one full cycle before the resend.
- start while busy=1 is ignored.
- Outputs are registered; no combinational path from input to output.

## Test plan
- Nominal flow: responder returns 0x01 0x01, then 0x01 0x03 with Param1=slot=3.
  - Required: two req_out assertions, two one-cycle Ack_out pulses.
  - Required: done with pass=1, error_code=0x00, digests_out equal to the response payload.
- Error response: DIGESTS answered with MessageType 0x7F, Param1=0x05 → done, pass=0, error_code=0x05, and no CHALLENGE request is issued.
- Timeout with recovery, TIMEOUT_CYCLES=8, MAX_RETRIES=2: no response → req_out drops after 8 cycles, then after a 1-cycle gap the same message is resent. Answering on the 3rd attempt → flow completes with pass=1.
- Timeout exhausted: never answer → 3 attempts, then done with error_code=0xFE, about 3×(8+2) cycles after start.
- Bad response contents:
  - version 0x02 → 0xFC
  - type 0x02 → 0xFD
  - CHALLENGE_AUTH Param1=0x01 with slot=3 → 0xFB.
- Mid-flow reset: assert reset low in WAIT_CHAL → req_out=0 and busy=0 immediately (asynchronously). After release, start begins again from GET_DIGESTS. A start pulse while busy=1 has no effect.
